// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - operand fetch and skew feeder for a SIZE x SIZE systolic array
// Optional abort input enabled by defining SYSTOLIC_FEED_ABORT_EN.
module systolic_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
`ifdef SYSTOLIC_FEED_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       rom_rd_en,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH*SIZE-1:0] rom_data_a,
  input  logic [DATA_WIDTH*SIZE-1:0] rom_data_b,
  output logic [DATA_WIDTH*SIZE-1:0] a_feed,
  output logic [DATA_WIDTH*SIZE-1:0] b_feed,
  output logic [SIZE-1:0]            feed_valid,
  output logic                       array_clear,
  output logic                       busy,
  output logic                       done
);

  // Counter covers both the fetch phase (DEPTH cycles) and the drain phase (2*SIZE cycles).
  localparam int CMAX = (DEPTH > 2*SIZE) ? DEPTH : 2*SIZE;
  localparam int CW   = $clog2(CMAX + 1);
  // Lane t needs t+1 stages (capture plus t delays); stages are packed as a triangle.
  localparam int NTAP = SIZE * (SIZE + 1) / 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
  logic                                clear_q, clear_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                dv_q, dv_d;
  logic [NTAP-1:0][DATA_WIDTH-1:0]     ta_q, ta_d, tb_q, tb_d;
  logic [SIZE-1:0]                     v_q, v_d;
  logic                                abort_w;

`ifdef SYSTOLIC_FEED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Sequencer: next state, fetch counter and registered control outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    addr_d  = '0;
    clear_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          rd_en_d = 1'b1;
          clear_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(DEPTH - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          rd_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(cnt_q + 1'b1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(2*SIZE - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w && (state_q == S_FETCH || state_q == S_DRAIN)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rd_en_d = 1'b0;
      addr_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Skew network: capture the returned vector, then delay lane t by t more cycles.
  always_comb begin
    dv_d = rd_en_q;
    ta_d = '0;
    tb_d = '0;
    v_d  = '0;
    for (int t = 0; t < SIZE; t++) begin
      for (int k = 0; k <= t; k++) begin
        if (k == 0) begin
          ta_d[t*(t+1)/2] = dv_q ? rom_data_a[DATA_WIDTH*t +: DATA_WIDTH] : '0;
          tb_d[t*(t+1)/2] = dv_q ? rom_data_b[DATA_WIDTH*t +: DATA_WIDTH] : '0;
        end else begin
          ta_d[t*(t+1)/2 + k] = ta_q[t*(t+1)/2 + k - 1];
          tb_d[t*(t+1)/2 + k] = tb_q[t*(t+1)/2 + k - 1];
        end
      end
    end
    v_d[0] = dv_q;
    for (int k = 1; k < SIZE; k++) begin
      v_d[k] = v_q[k-1];
    end
    if (abort_w && (state_q == S_FETCH || state_q == S_DRAIN)) begin
      dv_d = 1'b0;
      ta_d = '0;
      tb_d = '0;
      v_d  = '0;
    end
  end

  // Single register bank for the sequencer and skew stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dv_q    <= 1'b0;
      ta_q    <= '0;
      tb_q    <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      v_q     <= v_d;
    end
  end

  // Each lane output is the last stage of its own delay chain.
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    for (int t = 0; t < SIZE; t++) begin
      a_feed[DATA_WIDTH*t +: DATA_WIDTH] = ta_q[t*(t+1)/2 + t];
      b_feed[DATA_WIDTH*t +: DATA_WIDTH] = tb_q[t*(t+1)/2 + t];
    end
  end

  assign rom_rd_en   = rd_en_q;
  assign rom_addr    = addr_q;
  assign feed_valid  = v_q;
  assign array_clear = clear_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
